// File: rtl/ram_read_streamer_pkg.sv
// Shared RAM geometry, read-sequencer state encoding and the address wrap
// helper used by both the read streamer and the write-side agent.
package ram_pkg;

  localparam int RAM_DATA_WIDTH = 2;
  localparam int RAM_ADDR_WIDTH = 4;
  localparam int RAM_DEPTH      = 10;
  localparam int RAM_LEN_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // Wraps explicitly at the last valid location, since DEPTH need not be a power of two.
  function automatic logic [RAM_ADDR_WIDTH-1:0] next_addr(
    input logic [RAM_ADDR_WIDTH-1:0] addr,
    input logic [RAM_ADDR_WIDTH-1:0] last_addr
  );
    return (addr == last_addr) ? '0 : addr + RAM_ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/ram_read_streamer_if.sv
// Burst request, RAM read port and output stream of the read streamer.
interface ram_read_streamer_if
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int LEN_WIDTH  = RAM_LEN_WIDTH
) ();

  logic                  START;
  logic [ADDR_WIDTH-1:0] BASE_ADDR;
  logic [LEN_WIDTH-1:0]  LEN;
  logic                  BUSY;
  logic                  DONE;
  logic                  EN_RD;
  logic [ADDR_WIDTH-1:0] ADDR_RD;
  logic [DATA_WIDTH-1:0] D_RD;
  logic [DATA_WIDTH-1:0] OUT_DATA;
  logic                  OUT_VALID;
  logic                  OUT_READY;
  logic                  OUT_LAST;

  modport master (
    input  START, BASE_ADDR, LEN, D_RD, OUT_READY,
    output BUSY, DONE, EN_RD, ADDR_RD, OUT_DATA, OUT_VALID, OUT_LAST
  );

  modport slave (
    output START, BASE_ADDR, LEN, D_RD, OUT_READY,
    input  BUSY, DONE, EN_RD, ADDR_RD, OUT_DATA, OUT_VALID, OUT_LAST
  );

endinterface

// File: rtl/ram_read_streamer_fifo.sv
// Return buffer between the RAM read pipeline and the output stream;
// each entry carries a data word plus its end-of-burst flag.
module stream_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] level,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign level    = cnt;
  assign empty    = (cnt == '0);

endmodule

// File: rtl/ram_read_streamer.sv
// Burst reader for the dual-port RAM read port: issues sequential wrapped
// reads under buffer credit and streams the returned words out valid/ready.
//
//   state | meaning
//   IDLE  | waiting for an acceptable START
//   ISSUE | reads still to be issued, limited by free buffer credit
//   DRAIN | all reads issued, waiting for the final handshake
module ram_read_streamer
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DEPTH      = RAM_DEPTH,
  parameter int LEN_WIDTH  = RAM_LEN_WIDTH,
  parameter int BUF_DEPTH  = 4
) (
  input logic                CLK,
  input logic                RST,
  ram_read_streamer_if.master bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  rd_state_t             state, state_nxt;
  logic [LEN_WIDTH-1:0]  issue_cnt, ret_cnt, issue_left;
  logic [ADDR_WIDTH-1:0] addr_nxt_q, addr_rd_q, issue_addr;
  logic                  en_rd_q, cap_q, last_p1_q, last_p2_q, done_q;
  logic                  accept, issue, hs, hs_final;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_level;
  logic [DATA_WIDTH:0]   fifo_head;
  logic [CNT_W:0]        occupancy;

  // Credit covers words already buffered plus reads still in the RAM pipeline.
  assign occupancy  = (CNT_W+1)'(fifo_level) + (CNT_W+1)'(en_rd_q) + (CNT_W+1)'(cap_q);
  assign hs         = !fifo_empty && bus.OUT_READY;
  assign issue_addr = accept ? bus.BASE_ADDR : addr_nxt_q;
  assign issue_left = accept ? bus.LEN : issue_cnt;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    hs_final  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.START && bus.LEN != '0 && bus.BASE_ADDR <= LAST_ADDR) begin
          accept    = 1'b1;
          issue     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_cnt == '0) begin
          state_nxt = DRAIN;
        end else if (occupancy < (CNT_W+1)'(BUF_DEPTH)) begin
          issue = 1'b1;
          if (issue_cnt == LEN_WIDTH'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && ret_cnt == LEN_WIDTH'(1)) begin
          hs_final  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      addr_nxt_q <= '0;
      addr_rd_q  <= '0;
      en_rd_q    <= 1'b0;
      cap_q      <= 1'b0;
      last_p1_q  <= 1'b0;
      last_p2_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      en_rd_q   <= issue;
      cap_q     <= en_rd_q;
      last_p1_q <= issue && (issue_left == LEN_WIDTH'(1));
      last_p2_q <= last_p1_q;
      done_q    <= hs_final;
      if (issue) begin
        addr_rd_q  <= issue_addr;
        addr_nxt_q <= next_addr(issue_addr, LAST_ADDR);
        issue_cnt  <= issue_left - LEN_WIDTH'(1);
      end
      if (accept)  ret_cnt <= bus.LEN;
      else if (hs) ret_cnt <= ret_cnt - LEN_WIDTH'(1);
    end
  end

  stream_skid_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_WIDTH + 1),
    .CNT_W (CNT_W)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (cap_q),
    .push_data ({last_p2_q, bus.D_RD}),
    .pop       (hs),
    .pop_data  (fifo_head),
    .level     (fifo_level),
    .empty     (fifo_empty)
  );

  assign bus.BUSY      = (state != IDLE);
  assign bus.DONE      = done_q;
  assign bus.EN_RD     = en_rd_q;
  assign bus.ADDR_RD   = addr_rd_q;
  assign bus.OUT_VALID = !fifo_empty;
  assign bus.OUT_DATA  = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
  assign bus.OUT_LAST  = !fifo_empty && fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_ram_read_streamer.sv
// Scoreboard bench for ram_read_streamer with a registered-output RAM model
// preloaded with mem[i] = i % 4.
module tb_ram_read_streamer;
  import ram_pkg::*;

  localparam int DW    = 2;
  localparam int AW    = 4;
  localparam int DEPTH = 10;
  localparam int LW    = 4;
  localparam int BUF   = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  ram_read_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  ram_read_streamer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .LEN_WIDTH  (LW),
    .BUF_DEPTH  (BUF)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // RAM model: write port for preload, registered read port
  logic [DW-1:0] mem [2**AW];
  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  always @(posedge CLK) begin
    if (we) mem[wa] <= wd;
    if (bus.EN_RD) bus.D_RD <= mem[bus.ADDR_RD];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int            exp_addr_q[$];
  logic [DW:0]   exp_word_q[$];
  int            cyc = 0;
  int            en_pulses, hs_cnt, last_cnt, done_cnt, en_at_first_hs;
  int            last_hs_cyc = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.EN_RD === 1'b1) begin
        en_pulses++;
        chk("rd_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) chk("addr_rd", bus.ADDR_RD, exp_addr_q.pop_front());
      end
      if (prev_stall) begin
        chk("stall_valid", bus.OUT_VALID, 1);
        chk("stall_data", bus.OUT_DATA, prev_data);
        chk("stall_last", bus.OUT_LAST, prev_last);
      end
      if (bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1) begin
        logic [DW:0] w;
        if (hs_cnt == 0) en_at_first_hs = en_pulses;
        hs_cnt++;
        chk("hs_expected", exp_word_q.size() != 0, 1);
        if (exp_word_q.size() != 0) begin
          w = exp_word_q.pop_front();
          chk("out_data", bus.OUT_DATA, w[DW-1:0]);
          chk("out_last", bus.OUT_LAST, w[DW]);
        end
        if (bus.OUT_LAST === 1'b1) begin
          last_cnt++;
          last_hs_cyc = cyc;
        end
      end
      if (bus.DONE === 1'b1) begin
        done_cnt++;
        chk("done_latency", cyc - last_hs_cyc, 1);
        chk("busy_at_done", bus.BUSY, 0);
      end
      prev_stall = (bus.OUT_VALID === 1'b1) && (bus.OUT_READY === 1'b0);
      prev_data  = bus.OUT_DATA;
      prev_last  = bus.OUT_LAST;
    end
  end

  // OUT_READY driver: 0 = always ready, 1 = stall then ready, 2 = random
  int rdy_mode   = 0;
  int stall_left = 0;
  initial begin
    bus.OUT_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        1: begin
          if (stall_left > 0) begin
            bus.OUT_READY = 1'b0;
            stall_left--;
          end else begin
            bus.OUT_READY = 1'b1;
          end
        end
        2:       bus.OUT_READY = 1'($urandom_range(0, 1));
        default: bus.OUT_READY = 1'b1;
      endcase
    end
  end

  task automatic set_ready(input int mode, input int stall);
    @(negedge CLK);
    rdy_mode   = mode;
    stall_left = stall;
  endtask

  task automatic pulse_start(input int base, input int len);
    @(posedge CLK);
    #1;
    bus.START     = 1'b1;
    bus.BASE_ADDR = AW'(base);
    bus.LEN       = LW'(len);
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
  endtask

  task automatic start_burst(input int base, input int len);
    for (int n = 0; n < len; n++) begin
      int a;
      logic [DW:0] w;
      a = (base + n) % DEPTH;
      w = {(n == len - 1), DW'(a % 4)};
      exp_addr_q.push_back(a);
      exp_word_q.push_back(w);
    end
    en_pulses = 0;
    hs_cnt    = 0;
    last_cnt  = 0;
    done_cnt  = 0;
    pulse_start(base, len);
  endtask

  task automatic finish_burst();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 500) begin
      @(posedge CLK);
      t++;
    end
    chk("done_seen", done_cnt != 0, 1);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("done_once", done_cnt, 1);
    chk("last_once", last_cnt, 1);
    chk("addr_q_empty", exp_addr_q.size(), 0);
    chk("word_q_empty", exp_word_q.size(), 0);
    chk("busy_idle", bus.BUSY, 0);
    exp_addr_q.delete();
    exp_word_q.delete();
  endtask

  initial begin
    int t;
    bus.START     = 1'b0;
    bus.BASE_ADDR = '0;
    bus.LEN       = '0;

    for (int i = 0; i < DEPTH; i++) begin
      @(posedge CLK);
      #1;
      we = 1'b1;
      wa = AW'(i);
      wd = DW'(i % 4);
    end
    @(posedge CLK);
    #1;
    we = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_en_rd", bus.EN_RD, 0);
    chk("rst_addr_rd", bus.ADDR_RD, 0);
    chk("rst_valid", bus.OUT_VALID, 0);
    chk("rst_last", bus.OUT_LAST, 0);
    chk("rst_data", bus.OUT_DATA, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // basic burst with latency checks
    set_ready(0, 0);
    start_burst(2, 3);
    @(negedge CLK);
    chk("lat_en_k", bus.EN_RD, 1);
    chk("lat_busy_k", bus.BUSY, 1);
    chk("lat_valid_k", bus.OUT_VALID, 0);
    @(negedge CLK);
    chk("lat_valid_k1", bus.OUT_VALID, 0);
    @(negedge CLK);
    chk("lat_valid_k2", bus.OUT_VALID, 1);
    chk("lat_en_k2", bus.EN_RD, 1);
    @(negedge CLK);
    chk("lat_en_k3", bus.EN_RD, 0);
    finish_burst();

    // address wrap
    start_burst(8, 4);
    finish_burst();

    // backpressure
    set_ready(1, 6);
    start_burst(0, 8);
    finish_burst();
    chk("credit_limit", en_at_first_hs <= BUF, 1);
    set_ready(0, 0);

    // ignored requests
    pulse_start(0, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("len0_busy", bus.BUSY, 0);
    chk("len0_en_rd", bus.EN_RD, 0);
    pulse_start(10, 3);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("base10_busy", bus.BUSY, 0);
    chk("base10_en_rd", bus.EN_RD, 0);

    // START during an active burst
    start_burst(3, 6);
    repeat (2) @(posedge CLK);
    pulse_start(0, 1);
    finish_burst();

    // reset mid-burst
    start_burst(0, 8);
    t = 0;
    while (hs_cnt < 3 && t < 100) begin
      @(posedge CLK);
      t++;
    end
    chk("mid_hs_reached", hs_cnt >= 3, 1);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_addr_q.delete();
    exp_word_q.delete();
    @(negedge CLK);
    chk("mid_rst_busy", bus.BUSY, 0);
    chk("mid_rst_valid", bus.OUT_VALID, 0);
    chk("mid_rst_en_rd", bus.EN_RD, 0);
    chk("mid_rst_data", bus.OUT_DATA, 0);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("post_rst_valid", bus.OUT_VALID, 0);
    start_burst(5, 2);
    finish_burst();

    // random backpressure, long wrapped burst, stray START
    set_ready(2, 0);
    start_burst(7, 15);
    repeat (4) @(posedge CLK);
    pulse_start(1, 2);
    finish_burst();
    set_ready(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
